// File: rtl/vedic_mul_pipe_pkg.sv
// rtl/vedic_mul_pipe_pkg.sv - shared constants and elaboration helpers for the Vedic multiplier pipe
package vedic_pkg;

  // Register stages from operand capture to the output register
  localparam int VEDIC_LAT = 4;

  // Ceiling log2 for positive widths up to 2^31
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Operand width must be a power of two between 4 and 64 so every split halves cleanly
  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= 64) && ((1 << clog2(w)) == w);
  endfunction

endpackage

// File: rtl/vedic_mul_pipe_if.sv
// rtl/vedic_mul_pipe_if.sv - operand/result handshake bundle for vedic_mul_pipe
interface vedic_mul_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag
  );
endinterface

// File: rtl/vedic_mul_core.sv
// rtl/vedic_mul_core.sv - combinational unsigned W x W Urdhva-Tiryagbhyam multiplier
module vedic_mul_core #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  if (W == 2) begin : g_leaf
    // 2x2 leaf: vertical and crosswise terms built from AND/XOR gates
    logic c1;
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
    assign c1     = a_i[1] & b_i[0] & a_i[0] & b_i[1];
    assign p_o[2] = (a_i[1] & b_i[1]) ^ c1;
    assign p_o[3] = a_i[1] & b_i[1] & c1;
  end else begin : g_split
    localparam int H = W / 2;
    logic [W-1:0] q0, q1, q2, q3;
    logic [W+1:0] mid;

    vedic_mul_core #(.W(H)) u_q0 (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(q0));
    vedic_mul_core #(.W(H)) u_q1 (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(q1));
    vedic_mul_core #(.W(H)) u_q2 (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(q2));
    vedic_mul_core #(.W(H)) u_q3 (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(q3));

    // Crosswise sum plus the carry-out half of the low product; two guard bits cannot overflow
    assign mid = (W+2)'(q1) + (W+2)'(q2) + (W+2)'(q0[W-1:H]);
    assign p_o = {q3 + W'(mid[W+1:H]), mid[H-1:0], q0[H-1:0]};
  end

endmodule

// File: rtl/vedic_mul_pipe.sv
// rtl/vedic_mul_pipe.sv - 4-stage signed/unsigned Vedic multiplier with tag sideband and stall
module vedic_mul_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  vedic_mul_pipe_if.slave bus
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("vedic_mul_pipe: WIDTH must be a power of 2 in 4..64");
  end

  logic                 adv;
  logic [VEDIC_LAT-1:0] vld_d, vld_q;

  logic [WIDTH-1:0]     mag_a_d, mag_b_d;
  logic                 neg_d;
  logic [WIDTH-1:0]     s1_a_q, s1_b_q;
  logic                 s1_neg_q;
  logic [TAG_W-1:0]     s1_tag_q;

  logic [WIDTH-1:0]     q0_d, q1_d, q2_d, q3_d;
  logic [WIDTH-1:0]     s2_q0_q, s2_q1_q, s2_q2_q, s2_q3_q;
  logic                 s2_neg_q;
  logic [TAG_W-1:0]     s2_tag_q;

  logic [WIDTH+1:0]     mid_d, s3_mid_q;
  logic [H-1:0]         s3_lo_q;
  logic [WIDTH-1:0]     s3_q3_q;
  logic                 s3_neg_q;
  logic [TAG_W-1:0]     s3_tag_q;

  logic [WIDTH-1:0]     hi_d;
  logic [PW-1:0]        mag_p_d, prod_d, prod_q;
  logic [TAG_W-1:0]     tag_q;

  // The whole pipe moves only when the output slot is empty or being drained
  assign adv           = ~vld_q[VEDIC_LAT-1] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[VEDIC_LAT-1];
  assign bus.out_prod  = prod_q;
  assign bus.out_tag   = tag_q;

  // Fold signed operands to magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
  always_comb begin
    neg_d   = bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
    mag_a_d = (bus.in_signed & bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    mag_b_d = (bus.in_signed & bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
  end

  vedic_mul_core #(.W(H)) u_q0 (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[H-1:0]),     .p_o(q0_d));
  vedic_mul_core #(.W(H)) u_q1 (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[H-1:0]),     .p_o(q1_d));
  vedic_mul_core #(.W(H)) u_q2 (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[WIDTH-1:H]), .p_o(q2_d));
  vedic_mul_core #(.W(H)) u_q3 (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[WIDTH-1:H]), .p_o(q3_d));

  // Middle column sum and final assembly with optional two's-complement negation
  always_comb begin
    mid_d   = (WIDTH+2)'(s2_q1_q) + (WIDTH+2)'(s2_q2_q) + (WIDTH+2)'(s2_q0_q[WIDTH-1:H]);
    hi_d    = s3_q3_q + WIDTH'(s3_mid_q[WIDTH+1:H]);
    mag_p_d = {hi_d, s3_mid_q[H-1:0], s3_lo_q};
    prod_d  = s3_neg_q ? -mag_p_d : mag_p_d;
  end

  // Valid bits shift with the data so bubbles keep their slot
  always_comb begin
    vld_d = {vld_q[VEDIC_LAT-2:0], bus.in_valid};
  end

  // Valid chain: cleared by reset, held on stall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  // Data stages S1..S3: no reset needed, contents are qualified by the valid chain
  always_ff @(posedge clk_i) begin
    if (adv) begin
      s1_a_q   <= mag_a_d;
      s1_b_q   <= mag_b_d;
      s1_neg_q <= neg_d;
      s1_tag_q <= bus.in_tag;
      s2_q0_q  <= q0_d;
      s2_q1_q  <= q1_d;
      s2_q2_q  <= q2_d;
      s2_q3_q  <= q3_d;
      s2_neg_q <= s1_neg_q;
      s2_tag_q <= s1_tag_q;
      s3_mid_q <= mid_d;
      s3_lo_q  <= s2_q0_q[H-1:0];
      s3_q3_q  <= s2_q3_q;
      s3_neg_q <= s2_neg_q;
      s3_tag_q <= s2_tag_q;
    end
  end

  // Output stage S4: reset to zero, held stable while the consumer stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q <= '0;
      tag_q  <= '0;
    end else if (adv) begin
      prod_q <= prod_d;
      tag_q  <= s3_tag_q;
    end
  end

endmodule
